enemy_run_anim_ctrl: RTL and testbench
======================================

# enemy_run_anim_ctrl

Sequencer for one running-enemy sprite: it walks the run animation frames, plays the hit-flash/death sequence, and drives the sprite ROM address for the scan position. It sits between the VGA scan counters and the enemy sprite ROM plus its 8-entry palette. It delivers the 3-bit palette index and a pixel-on flag to the frame compositor.

## Interface
Parameters:
- SPR_W, 32, sprite width in pixels
- SPR_H, 32, sprite height in pixels
- N_FRAMES, 3, run animation frames stored back-to-back in ROM
- FRAME_TICKS, 8, frame_start pulses per animation step
- HIT_TICKS, 32, frame_start pulses spent in hit flash
- ADDR_W, 12, ROM address width (≥ clog2(N_FRAMES·SPR_W·SPR_H))

Ports:
- Clk  in  1  system clock; the single clock domain
- Reset  in  1  synchronous, active-high
- frame_start  in  1  one-cycle pulse per video frame (vsync)
- run  in  1  level; enemy moving
- hit  in  1  pulse; enemy struck
- respawn  in  1  pulse; restart enemy
- facing_left  in  1  horizontal mirror
- pos_x, pos_y  in  10 each  sprite top-left on screen
- DrawX, DrawY  in  10 each  current scan pixel
- rom_addr  out  ADDR_W  registered sprite ROM address
- rom_index  in  3  ROM data, valid 1 cycle after rom_addr
- pal_index  out  3  palette index to the palette (= rom_index)
- sprite_on  out  1  pixel is opaque sprite pixel
- anim_frame  out  clog2(N_FRAMES)  current frame
- dead  out  1  high in DEAD

## Operation
- States: IDLE, RUN, HIT, DEAD. Reset → IDLE, anim_frame=0, tick_cnt=0, hit_cnt=0, rom_addr=0, all delayed flags 0, sprite_on=0, dead=0.
- Priority each cycle: respawn > hit > run/frame_start.
- respawn (any state): next state IDLE, anim_frame=0, tick_cnt=0, hit_cnt=0.
- IDLE: visible; anim_frame held at 0. hit → HIT; else run=1 → RUN.
- RUN: visible. hit → HIT with anim_frame frozen. run=0 → IDLE with anim_frame=0 and tick_cnt=0. On frame_start, tick_cnt+1. When tick_cnt==FRAME_TICKS-1, tick_cnt=0 and anim_frame advances, wrapping N_FRAMES-1 → 0.
- HIT: hit and run ignored. On frame_start, hit_cnt+1. Visible = ~hit_cnt[2], so the sprite blinks every 4 frames. On frame_start with hit_cnt==HIT_TICKS-1 → DEAD, hit_cnt=0.
- DEAD: not visible; dead=1; only respawn exits.
- Box test (11-bit unsigned, no wrap): inbox = DrawX≥pos_x ∧ DrawX<pos_x+SPR_W ∧ DrawY≥pos_y ∧ DrawY<pos_y+SPR_H.
- rx = DrawX−pos_x, ry = DrawY−pos_y. If facing_left, rx' = SPR_W−1−rx; else rx' = rx.
- Address = anim_frame·SPR_W·SPR_H + ry·SPR_W + rx', truncated to ADDR_W. When outside the box, rom_addr is don't-care, but the register still updates.
- Index 0 is the transparent key colour: sprite_on = inbox_d ∧ visible_d ∧ (rom_index≠0).

## Timing
- Stage 0: DrawX/DrawY/pos inputs combinational.
- Clock edge 1: rom_addr, inbox_d, visible_d registered.
- Cycle 1: ROM samples rom_addr; rom_index valid at cycle 2.
- pal_index and sprite_on are valid 2 cycles after DrawX/DrawY; the compositor delays its own coordinates by 2.
- State, anim_frame and counter updates occur on the edge where frame_start=1. A hit in that same cycle takes the HIT transition, and tick_cnt does not advance.
- visible_d is sampled per pixel. A state change mid-line takes effect on the next pixel, delayed by the pipeline.
- Reset mid-frame: next cycle all outputs at reset values; sprite_on=0 until the pipeline refills (2 cycles).
- dead and anim_frame are registered state outputs; there is no pipeline delay.

## Test plan
- Reset, run=1, 8 frame_start pulses → anim_frame 0→1 on the 8th. After 24 pulses, anim_frame=0 (wrap).
- anim_frame=1, pos=(100,50), DrawX=105, DrawY=52, facing_left=0 → rom_addr=1093 two... one cycle later. facing_left=1 → 1114.
- ROM returns index 0 inside the box → sprite_on=0. Index 5 → sprite_on=1, pal_index=5. DrawX=132 (outside) → sprite_on=0.
- hit in RUN at anim_frame=2 → HIT, anim_frame stays 2. sprite_on is gated off for hit_cnt 4–7, 12–15, …. After 32 frame_starts, dead=1 and sprite_on=0.
- hit and respawn in the same cycle while in RUN → IDLE, anim_frame=0. hit and frame_start together at tick_cnt=7 → HIT, anim_frame unchanged.
- Reset asserted in HIT with hit_cnt=20 → next cycle IDLE, dead=0, sprite_on=0. After release, the first hit restarts the count from 0.

Source files
------------

// File: rtl/enemy_run_anim_ctrl.sv
// enemy_run_anim_ctrl: run-animation / hit-flash / death sequencer for one
// enemy sprite, plus the scan-position to sprite-ROM address pipeline.
module enemy_run_anim_ctrl #(
    parameter int unsigned SPR_W       = 32,
    parameter int unsigned SPR_H       = 32,
    parameter int unsigned N_FRAMES    = 3,
    parameter int unsigned FRAME_TICKS = 8,
    parameter int unsigned HIT_TICKS   = 32,
    parameter int unsigned ADDR_W      = 12,
    localparam int unsigned FRAME_W    = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_start,
    input  logic              run,
    input  logic              hit,
    input  logic              respawn,
    input  logic              facing_left,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [2:0]        rom_index,
    output logic [2:0]        pal_index,
    output logic              sprite_on,
    output logic [FRAME_W-1:0] anim_frame,
    output logic              dead
);

    localparam int unsigned TICK_W     = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int unsigned HIT_W      = (HIT_TICKS > 8) ? $clog2(HIT_TICKS) : 3;
    localparam int unsigned CALC_W     = 32;
    localparam int unsigned FRAME_SIZE = SPR_W * SPR_H;

    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(FRAME_TICKS - 1);
    localparam logic [HIT_W-1:0]   HIT_LAST   = HIT_W'(HIT_TICKS - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(N_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HIT  = 2'd2,
        DEAD = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [FRAME_W-1:0]  anim_next;
    logic [TICK_W-1:0]   tick_cnt;
    logic [TICK_W-1:0]   tick_next;
    logic [HIT_W-1:0]    hit_cnt;
    logic [HIT_W-1:0]    hit_next;
    logic                visible;

    logic [10:0]         x_lo;
    logic [10:0]         x_hi;
    logic [10:0]         y_lo;
    logic [10:0]         y_hi;
    logic [10:0]         px;
    logic [10:0]         py;
    logic                inbox;
    logic [9:0]          rx;
    logic [9:0]          ry;
    logic [9:0]          rx_m;
    logic [CALC_W-1:0]   addr_full;

    logic                inbox_d1;
    logic                inbox_d2;
    logic                visible_d1;
    logic                visible_d2;

    // Next-state, counter and visibility logic; respawn overrides everything
    always_comb begin
        state_next = state;
        anim_next  = anim_frame;
        tick_next  = tick_cnt;
        hit_next   = hit_cnt;
        visible    = 1'b0;

        unique case (state)
            IDLE: begin
                visible   = 1'b1;
                anim_next = '0;
                tick_next = '0;
                if (hit) begin
                    state_next = HIT;
                    hit_next   = '0;
                end else if (run) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                visible = 1'b1;
                if (hit) begin
                    // Freeze the frame; the tick counter does not advance
                    state_next = HIT;
                    hit_next   = '0;
                end else if (!run) begin
                    state_next = IDLE;
                    anim_next  = '0;
                    tick_next  = '0;
                end else if (frame_start) begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_next = '0;
                        anim_next = (anim_frame == FRAME_LAST) ? '0
                                  : anim_frame + FRAME_W'(1);
                    end else begin
                        tick_next = tick_cnt + TICK_W'(1);
                    end
                end
            end
            HIT: begin
                // Blink: hidden for hit_cnt values with bit 2 set
                visible = ~hit_cnt[2];
                if (frame_start) begin
                    if (hit_cnt == HIT_LAST) begin
                        state_next = DEAD;
                        hit_next   = '0;
                    end else begin
                        hit_next = hit_cnt + HIT_W'(1);
                    end
                end
            end
            DEAD: begin
                visible = 1'b0;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (respawn) begin
            state_next = IDLE;
            anim_next  = '0;
            tick_next  = '0;
            hit_next   = '0;
        end
    end

    // State, animation and counter registers; dead tracks the next state
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            anim_frame <= '0;
            tick_cnt   <= '0;
            hit_cnt    <= '0;
            dead       <= 1'b0;
        end else begin
            state      <= state_next;
            anim_frame <= anim_next;
            tick_cnt   <= tick_next;
            hit_cnt    <= hit_next;
            dead       <= (state_next == DEAD);
        end
    end

    // Box test in 11 bits so pos + size never wraps, then mirrored address
    always_comb begin
        px        = 11'(DrawX);
        py        = 11'(DrawY);
        x_lo      = 11'(pos_x);
        y_lo      = 11'(pos_y);
        x_hi      = 11'(pos_x) + 11'(SPR_W);
        y_hi      = 11'(pos_y) + 11'(SPR_H);
        inbox     = (px >= x_lo) && (px < x_hi) && (py >= y_lo) && (py < y_hi);
        rx        = DrawX - pos_x;
        ry        = DrawY - pos_y;
        rx_m      = facing_left ? (10'(SPR_W - 1) - rx) : rx;
        addr_full = CALC_W'(anim_frame) * CALC_W'(FRAME_SIZE)
                  + CALC_W'(ry) * CALC_W'(SPR_W)
                  + CALC_W'(rx_m);
    end

    // Two-stage pixel pipeline aligning box/visibility flags with ROM data
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_addr   <= '0;
            inbox_d1   <= 1'b0;
            inbox_d2   <= 1'b0;
            visible_d1 <= 1'b0;
            visible_d2 <= 1'b0;
        end else begin
            rom_addr   <= ADDR_W'(addr_full);
            inbox_d1   <= inbox;
            inbox_d2   <= inbox_d1;
            visible_d1 <= visible;
            visible_d2 <= visible_d1;
        end
    end

    // Index 0 is the transparent key colour
    assign pal_index = rom_index;
    assign sprite_on = inbox_d2 && visible_d2 && (rom_index != 3'd0);

endmodule

// File: tb/tb_enemy_run_anim_ctrl.sv
// Directed bench for enemy_run_anim_ctrl with a registered one-value ROM model.
module tb_enemy_run_anim_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_start;
    logic        run;
    logic        hit;
    logic        respawn;
    logic        facing_left;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic [11:0] rom_addr;
    logic [2:0]  rom_index;
    logic [2:0]  pal_index;
    logic        sprite_on;
    logic [1:0]  anim_frame;
    logic        dead;

    logic [2:0]  rom_val;
    int          n_checks = 0;
    int          n_fail   = 0;

    enemy_run_anim_ctrl dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_start (frame_start),
        .run         (run),
        .hit         (hit),
        .respawn     (respawn),
        .facing_left (facing_left),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .rom_addr    (rom_addr),
        .rom_index   (rom_index),
        .pal_index   (pal_index),
        .sprite_on   (sprite_on),
        .anim_frame  (anim_frame),
        .dead        (dead)
    );

    always #5 Clk = ~Clk;

    // Synchronous ROM: data appears one cycle after the address edge
    always_ff @(posedge Clk) rom_index <= rom_val;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse(input int n);
        for (int i = 0; i < n; i++) begin
            frame_start = 1'b1;
            step();
            frame_start = 1'b0;
            step();
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        Reset = 1'b1; frame_start = 1'b0; run = 1'b0; hit = 1'b0; respawn = 1'b0;
        facing_left = 1'b0; pos_x = 10'd100; pos_y = 10'd50;
        DrawX = 10'd105; DrawY = 10'd52; rom_val = 3'd0;
        step(); step();
        check("rst_anim", 32'(anim_frame), 0);
        check("rst_dead", 32'(dead), 0);
        check("rst_addr", 32'(rom_addr), 0);
        check("rst_sprite_on", 32'(sprite_on), 0);

        // Run animation: advance on 8th pulse, wrap after 24
        Reset = 1'b0; run = 1'b1;
        step();
        pulse(7);  check("anim_before_8th", 32'(anim_frame), 0);
        pulse(1);  check("anim_8th", 32'(anim_frame), 1);
        pulse(8);  check("anim_16th", 32'(anim_frame), 2);
        pulse(8);  check("anim_wrap", 32'(anim_frame), 0);

        // Address: frame 1, (105,52) relative to (100,50)
        pulse(8);
        check("addr_right", 32'(rom_addr), 1093);
        facing_left = 1'b1;
        step();
        check("addr_left", 32'(rom_addr), 1114);

        // Transparency and opaque pixel
        step(); step();
        check("transparent", 32'(sprite_on), 0);
        rom_val = 3'd5;
        step();
        check("opaque_on", 32'(sprite_on), 1);
        check("pal_index", 32'(pal_index), 5);

        // Right edge: 131 inside (mirrored rx'=0), 132 outside after 2-cycle delay
        DrawX = 10'd131;
        step();
        check("addr_edge_left", 32'(rom_addr), 1088);
        DrawX = 10'd132;
        step();
        check("edge_pipe_still_on", 32'(sprite_on), 1);
        step();
        check("edge_out", 32'(sprite_on), 0);
        DrawX = 10'd105; facing_left = 1'b0;

        // Hit at frame 2: frame frozen, blink, then death after 32 pulses
        pulse(8);
        check("anim_pre_hit", 32'(anim_frame), 2);
        hit = 1'b1; step(); hit = 1'b0;
        step(); step();
        check("hit_freeze", 32'(anim_frame), 2);
        check("hit_visible0", 32'(sprite_on), 1);
        pulse(4); step();
        check("blink_off", 32'(sprite_on), 0);
        pulse(4); step();
        check("blink_on", 32'(sprite_on), 1);
        pulse(23);
        check("not_dead_31", 32'(dead), 0);
        pulse(1);
        check("dead_32", 32'(dead), 1);
        step();
        check("dead_hidden", 32'(sprite_on), 0);
        check("dead_anim", 32'(anim_frame), 2);

        // Respawn from DEAD
        respawn = 1'b1; step(); respawn = 1'b0;
        check("respawn_dead", 32'(dead), 0);
        check("respawn_anim", 32'(anim_frame), 0);
        step();
        pulse(8);
        check("run_after_respawn", 32'(anim_frame), 1);

        // respawn beats hit in the same cycle; then RUN counting resumes
        hit = 1'b1; respawn = 1'b1; step(); hit = 1'b0; respawn = 1'b0;
        check("hit_respawn_anim", 32'(anim_frame), 0);
        check("hit_respawn_dead", 32'(dead), 0);
        step();
        pulse(8);
        check("respawn_wins", 32'(anim_frame), 1);

        // hit with frame_start at tick 7: HIT taken, frame unchanged
        pulse(7);
        frame_start = 1'b1; hit = 1'b1; step(); frame_start = 1'b0; hit = 1'b0;
        check("hit_fs_same", 32'(anim_frame), 1);
        pulse(20);
        check("hit20_alive", 32'(dead), 0);

        // Reset mid-HIT at hit_cnt=20
        Reset = 1'b1; step();
        check("rst2_anim", 32'(anim_frame), 0);
        check("rst2_dead", 32'(dead), 0);
        check("rst2_sprite_on", 32'(sprite_on), 0);
        check("rst2_addr", 32'(rom_addr), 0);
        Reset = 1'b0;
        step();
        check("refill_off", 32'(sprite_on), 0);
        step();
        check("refill_on", 32'(sprite_on), 1);

        // First hit after reset counts from 0
        hit = 1'b1; step(); hit = 1'b0;
        pulse(31);
        check("restart_31", 32'(dead), 0);
        pulse(1);
        check("restart_32", 32'(dead), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
